// File: rtl/video_pkg.sv
// Shared definitions for the video output path: mode codes, default BT.709
// luma coefficients (Q0.8) and the channel-maximum helper.
package video_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_COLOUR     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_GREEN      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_AMBER      = 3'd2;
  localparam logic [MODE_W-1:0] MODE_WHITE      = 3'd3;
  localparam logic [MODE_W-1:0] MODE_TINT       = 3'd4;
  localparam logic [MODE_W-1:0] MODE_INV_COLOUR = 3'd5;
  localparam logic [MODE_W-1:0] MODE_INV_MONO   = 3'd6;

  // BT.709 coefficients scaled by 256; they sum to exactly 256.
  localparam int unsigned LUMA_KR = 54;
  localparam int unsigned LUMA_KG = 183;
  localparam int unsigned LUMA_KB = 19;

  // Largest value of a cw-bit colour channel, 2^cw - 1.
  function automatic int unsigned chan_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/luma_calc.sv
// Two-stage luma calculator: registers the pixel (S1), then forms
// Y = (R*KR + G*KG + B*KB) >> 8 with a saturating guard (S2).
// Ports: clk_vga/rst (sync, active-high); r_in/g_in/b_in source pixel;
// y_out luma; r_out/g_out/b_out the pixel delayed to stay aligned with y_out.
module luma_calc
  import video_pkg::*;
#(
  parameter int unsigned CW = 6,
  parameter int unsigned KR = LUMA_KR,
  parameter int unsigned KG = LUMA_KG,
  parameter int unsigned KB = LUMA_KB
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic [CW-1:0] y_out,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out
);

  localparam int unsigned PW = CW + 8;   // product width
  localparam int unsigned SW = CW + 10;  // sum of three products
  localparam int unsigned YW = CW + 2;   // sum >> 8, before clamp
  localparam int unsigned M  = chan_max(CW);

  logic [CW-1:0] r_s1, g_s1, b_s1;
  logic [PW-1:0] pr_c, pg_c, pb_c;
  logic [SW-1:0] sum_c;
  logic [YW-1:0] y_wide_c;
  logic [CW-1:0] y_c;

  // S1: register the source pixel
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_s1 <= '0;
      g_s1 <= '0;
      b_s1 <= '0;
    end else begin
      r_s1 <= r_in;
      g_s1 <= g_in;
      b_s1 <= b_in;
    end
  end

  // Multiply-add-shift; the clamp only matters with mis-set coefficients
  always_comb begin
    pr_c     = PW'(r_s1) * PW'(KR);
    pg_c     = PW'(g_s1) * PW'(KG);
    pb_c     = PW'(b_s1) * PW'(KB);
    sum_c    = SW'(pr_c) + SW'(pg_c) + SW'(pb_c);
    y_wide_c = YW'(sum_c >> 8);
    if (y_wide_c > YW'(M)) begin
      y_c = CW'(M);
    end else begin
      y_c = y_wide_c[CW-1:0];
    end
  end

  // S2: register luma and the aligned pixel copy
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      y_out <= '0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else begin
      y_out <= y_c;
      r_out <= r_s1;
      g_out <= g_s1;
      b_out <= b_s1;
    end
  end

endmodule

// File: rtl/video_mono_filter.sv
// Pipelined monochrome/tint filter between the system video output and the
// VGA pins. Fixed 3-cycle latency for pixels, syncs and blank. Mode and tint
// are latched only on the vsync inactive-to-active edge so frames never tear.
// Ports: clk_vga/rst (sync, active-high); r_in/g_in/b_in, hsync_in, vsync_in,
// blank_in source video; mode_req, tint_r/g/b requested settings;
// r_out/g_out/b_out, hsync_out, vsync_out, blank_out filtered video;
// mode_active the mode currently applied.
module video_mono_filter
  import video_pkg::*;
#(
  parameter int unsigned CW        = 6,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned KR        = LUMA_KR,
  parameter int unsigned KG        = LUMA_KG,
  parameter int unsigned KB        = LUMA_KB
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic [CW-1:0]     r_in,
  input  logic [CW-1:0]     g_in,
  input  logic [CW-1:0]     b_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic [MODE_W-1:0] mode_req,
  input  logic [CW-1:0]     tint_r,
  input  logic [CW-1:0]     tint_g,
  input  logic [CW-1:0]     tint_b,
  output logic [CW-1:0]     r_out,
  output logic [CW-1:0]     g_out,
  output logic [CW-1:0]     b_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic [MODE_W-1:0] mode_active
);

  localparam int unsigned M      = chan_max(CW);
  localparam logic [CW-1:0] MAXV = CW'(M);
  localparam logic SYNC_ACT      = (VSYNC_POL != 0);

  // (Y*t + Y) >> CW; t = max gives Y, t = 0 gives 0
  function automatic logic [CW-1:0] tint_ch(input logic [CW-1:0] y,
                                            input logic [CW-1:0] t);
    logic [2*CW-1:0] p;
    p = (2*CW)'(y) * ((2*CW)'(t) + (2*CW)'(1));
    return CW'(p >> CW);
  endfunction

  logic                vs_prev;
  logic                frame_edge_c;
  logic [CW-1:0]       tint_sh_r, tint_sh_g, tint_sh_b;

  logic [MODE_W-1:0]   mode_s1, mode_s2;
  logic [CW-1:0]       tint_s1_r, tint_s1_g, tint_s1_b;
  logic [CW-1:0]       tint_s2_r, tint_s2_g, tint_s2_b;
  logic [1:0]          hs_pipe, vs_pipe, bl_pipe;

  logic [CW-1:0]       y_s2, r_s2, g_s2, b_s2;
  logic [CW-1:0]       r_c, g_c, b_c;

  assign frame_edge_c = (vsync_in == SYNC_ACT) && (vs_prev != SYNC_ACT);

  // Frame-boundary latch of mode and tint
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_prev     <= ~SYNC_ACT;
      mode_active <= MODE_COLOUR;
      tint_sh_r   <= '1;
      tint_sh_g   <= '1;
      tint_sh_b   <= '1;
    end else begin
      vs_prev <= vsync_in;
      if (frame_edge_c) begin
        mode_active <= mode_req;
        tint_sh_r   <= tint_r;
        tint_sh_g   <= tint_g;
        tint_sh_b   <= tint_b;
      end
    end
  end

  luma_calc #(
    .CW (CW),
    .KR (KR),
    .KG (KG),
    .KB (KB)
  ) u_luma (
    .clk_vga (clk_vga),
    .rst     (rst),
    .r_in    (r_in),
    .g_in    (g_in),
    .b_in    (b_in),
    .y_out   (y_s2),
    .r_out   (r_s2),
    .g_out   (g_s2),
    .b_out   (b_s2)
  );

  // Mode/tint travel with each pixel so a mid-pipeline change never leaks in
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      mode_s1   <= MODE_COLOUR;
      mode_s2   <= MODE_COLOUR;
      tint_s1_r <= '1;
      tint_s1_g <= '1;
      tint_s1_b <= '1;
      tint_s2_r <= '1;
      tint_s2_g <= '1;
      tint_s2_b <= '1;
      hs_pipe   <= {2{~SYNC_ACT}};
      vs_pipe   <= {2{~SYNC_ACT}};
      bl_pipe   <= 2'b11;
    end else begin
      mode_s1   <= mode_active;
      mode_s2   <= mode_s1;
      tint_s1_r <= tint_sh_r;
      tint_s1_g <= tint_sh_g;
      tint_s1_b <= tint_sh_b;
      tint_s2_r <= tint_s1_r;
      tint_s2_g <= tint_s1_g;
      tint_s2_b <= tint_s1_b;
      hs_pipe   <= {hs_pipe[0], hsync_in};
      vs_pipe   <= {vs_pipe[0], vsync_in};
      bl_pipe   <= {bl_pipe[0], blank_in};
    end
  end

  // S3 mode mux with blank forcing
  always_comb begin
    r_c = r_s2;
    g_c = g_s2;
    b_c = b_s2;
    case (mode_s2)
      MODE_GREEN: begin
        r_c = '0;
        g_c = y_s2;
        b_c = '0;
      end
      MODE_AMBER: begin
        r_c = y_s2;
        g_c = y_s2 >> 1;
        b_c = '0;
      end
      MODE_WHITE: begin
        r_c = y_s2;
        g_c = y_s2;
        b_c = y_s2;
      end
      MODE_TINT: begin
        r_c = tint_ch(y_s2, tint_s2_r);
        g_c = tint_ch(y_s2, tint_s2_g);
        b_c = tint_ch(y_s2, tint_s2_b);
      end
      MODE_INV_COLOUR: begin
        r_c = MAXV - r_s2;
        g_c = MAXV - g_s2;
        b_c = MAXV - b_s2;
      end
      MODE_INV_MONO: begin
        r_c = MAXV - y_s2;
        g_c = MAXV - y_s2;
        b_c = MAXV - y_s2;
      end
      default: ;
    endcase
    if (bl_pipe[1]) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
  end

  // S3: output registers
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= ~SYNC_ACT;
      vsync_out <= ~SYNC_ACT;
      blank_out <= 1'b1;
    end else begin
      r_out     <= r_c;
      g_out     <= g_c;
      b_out     <= b_c;
      hsync_out <= hs_pipe[1];
      vsync_out <= vs_pipe[1];
      blank_out <= bl_pipe[1];
    end
  end

endmodule

// File: tb/tb_video_mono_filter.sv
// Self-checking bench for video_mono_filter (CW = 6, active-low syncs).
// A behavioural model computes each expected output word when the input is
// applied; the word is compared with the DUT output three cycles later.
module tb_video_mono_filter;
  import video_pkg::*;

  localparam int CW = 6;
  localparam int M  = 63;

  logic          clk_vga = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
  logic [2:0]    mode_req = '0;
  logic [CW-1:0] tint_r = '1, tint_g = '1, tint_b = '1;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hsync_out, vsync_out, blank_out;
  logic [2:0]    mode_active;

  always #5 clk_vga = ~clk_vga;

  video_mono_filter #(
    .CW        (CW),
    .VSYNC_POL (0)
  ) dut (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .blank_in    (blank_in),
    .mode_req    (mode_req),
    .tint_r      (tint_r),
    .tint_g      (tint_g),
    .tint_b      (tint_b),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out),
    .mode_active (mode_active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model state: mode/tint in force for the next pixel, last vsync seen
  int          m_mode;
  int          m_tr, m_tg, m_tb;
  bit          m_vs_prev;
  logic [31:0] exp_q[$];

  // Current stimulus levels held between steps
  int cur_mreq = 0, cur_tr = M, cur_tg = M, cur_tb = M;
  bit cur_hs = 1'b1, cur_vs = 1'b1, cur_bl = 1'b0;

  function automatic logic [31:0] pack(input int r, input int g, input int b,
                                       input bit hs, input bit vs, input bit bl);
    return (32'(r) << 15) | (32'(g) << 9) | (32'(b) << 3) |
           (32'(hs) << 2) | (32'(vs) << 1) | 32'(bl);
  endfunction

  function automatic int luma(input int r, input int g, input int b);
    int y;
    y = (r * 54 + g * 183 + b * 19) / 256;
    return (y > M) ? M : y;
  endfunction

  function automatic logic [31:0] ref_out(input int mode, input int r, input int g,
                                          input int b, input bit hs, input bit vs,
                                          input bit bl);
    int y, ro, go, bo;
    y = luma(r, g, b);
    case (mode)
      1: begin ro = 0;     go = y;     bo = 0;     end
      2: begin ro = y;     go = y / 2; bo = 0;     end
      3: begin ro = y;     go = y;     bo = y;     end
      4: begin
        ro = (y * m_tr + y) / 64;
        go = (y * m_tg + y) / 64;
        bo = (y * m_tb + y) / 64;
      end
      5: begin ro = M - r; go = M - g; bo = M - b; end
      6: begin ro = M - y; go = M - y; bo = M - y; end
      default: begin ro = r; go = g; bo = b; end
    endcase
    if (bl) begin
      ro = 0; go = 0; bo = 0;
    end
    return pack(ro, go, bo, hs, vs, bl);
  endfunction

  // One clock: check what is due, apply the new input, advance the model
  task automatic step(input bit rs, input int r, input int g, input int b);
    @(negedge clk_vga);
    check_val("mode_active", 32'(mode_active), 32'(m_mode));
    if (exp_q.size() == 3)
      check_val("pixel{r,g,b,hs,vs,bl}",
                32'({r_out, g_out, b_out, hsync_out, vsync_out, blank_out}),
                exp_q.pop_front());
    rst      = rs;
    r_in     = CW'(r);
    g_in     = CW'(g);
    b_in     = CW'(b);
    hsync_in = cur_hs;
    vsync_in = cur_vs;
    blank_in = cur_bl;
    mode_req = 3'(cur_mreq);
    tint_r   = CW'(cur_tr);
    tint_g   = CW'(cur_tg);
    tint_b   = CW'(cur_tb);
    if (rs) begin
      exp_q.delete();
      repeat (3) exp_q.push_back(pack(0, 0, 0, 1'b1, 1'b1, 1'b1));
      m_mode = 0;
      m_tr = M; m_tg = M; m_tb = M;
      m_vs_prev = 1'b1;
    end else begin
      exp_q.push_back(ref_out(m_mode, r, g, b, cur_hs, cur_vs, cur_bl));
      if (!cur_vs && m_vs_prev) begin
        m_mode = cur_mreq;
        m_tr = cur_tr; m_tg = cur_tg; m_tb = cur_tb;
      end
      m_vs_prev = cur_vs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  // Blanked vsync pulse that latches cur_mreq / cur_t*
  task automatic frame_edge(input int mode, input int tr, input int tg, input int tb);
    cur_mreq = mode; cur_tr = tr; cur_tg = tg; cur_tb = tb;
    cur_bl = 1'b1;
    cur_vs = 1'b0;
    idle(2);
    cur_vs = 1'b1;
    idle(1);
    cur_bl = 1'b0;
  endtask

  initial begin
    m_mode = 0; m_tr = M; m_tg = M; m_tb = M; m_vs_prev = 1'b1;

    cur_bl = 1'b1;
    repeat (3) step(1'b1, 0, 0, 0);
    cur_bl = 1'b0;
    idle(3);

    // White mode luma of primaries
    frame_edge(3, M, M, M);
    step(1'b0, 63, 63, 63);
    step(1'b0, 63, 0, 0);
    step(1'b0, 0, 63, 0);
    step(1'b0, 0, 0, 63);
    idle(3);

    // Amber then green
    frame_edge(2, M, M, M);
    step(1'b0, 0, 63, 0);
    idle(3);
    frame_edge(1, M, M, M);
    step(1'b0, 0, 63, 0);
    idle(3);

    // Tint
    frame_edge(4, 32, 0, 63);
    step(1'b0, 63, 63, 63);
    step(1'b0, 40, 20, 10);
    idle(3);
    frame_edge(4, 63, 63, 63);
    step(1'b0, 0, 63, 0);
    idle(3);

    // Inverse colour
    frame_edge(5, M, M, M);
    step(1'b0, 10, 20, 30);
    idle(3);

    // Mid-frame request ignored until the next vsync edge
    frame_edge(0, M, M, M);
    cur_mreq = 3;
    cur_tr = 5;
    for (int i = 0; i < 8; i++)
      step(1'b0, $urandom_range(0, M), $urandom_range(0, M), $urandom_range(0, M));
    frame_edge(3, M, M, M);
    step(1'b0, 63, 0, 0);
    idle(3);

    // Blank forcing and hsync pulse alignment in colour mode
    frame_edge(0, M, M, M);
    cur_bl = 1'b1;
    step(1'b0, 63, 63, 63);
    cur_bl = 1'b0;
    step(1'b0, 63, 63, 63);
    cur_hs = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 12, 34, 56);
    cur_hs = 1'b1;
    idle(4);

    // Reset mid-frame while in inverse mono
    frame_edge(6, M, M, M);
    cur_mreq = 2;
    step(1'b0, 50, 10, 5);
    step(1'b0, 1, 2, 3);
    step(1'b1, 63, 63, 63);
    for (int i = 0; i < 6; i++) step(1'b0, 20 + i, 40, 60);

    // Randomised traffic with occasional frame edges and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  cur_hs = ~cur_hs;
      if ($urandom_range(0, 39) == 0) cur_vs = ~cur_vs;
      cur_bl   = ($urandom_range(0, 3) == 0);
      cur_mreq = $urandom_range(0, 7);
      cur_tr   = $urandom_range(0, M);
      cur_tg   = $urandom_range(0, M);
      cur_tb   = $urandom_range(0, M);
      step(($urandom_range(0, 499) == 0), $urandom_range(0, M),
           $urandom_range(0, M), $urandom_range(0, M));
    end
    cur_vs = 1'b1;
    cur_hs = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
